// File: rtl/fx2_in_ep_fifo.sv
// rtl/fx2_in_ep_fifo.sv - FX2 slave-FIFO IN endpoint model with packet-oriented host drain port
//
// Purpose: buffers NUM_PKTS packets of up to PKT_WORDS words written over the
// FX2 slave-FIFO write interface, and presents committed packets one word at
// a time to a host-side reader with length and end-of-packet information.
//
// Optional trace: define FX2_MODEL_TRACE_EN to print accepted writes, commits
// and overflow events; functional behaviour is identical either way.
//
// Ports:
//   ifclk          interface clock, all logic on rising edge
//   reset_n        asynchronous active-low reset
//   fifoadr        endpoint select; this instance responds when == FIFOADR
//   data           FD write data
//   slwr           write strobe, active high
//   pktend         commit current packet, active high
//   full           no free packet slot; writes and pktend are refused
//   host_rd        host pops one word (or one zero-length packet)
//   host_data      word at head of oldest committed packet
//   host_pkt_avail at least one committed packet
//   host_pkt_len   length in words of oldest committed packet
//   host_eop       host_data is the last word of its packet, or a ZLP
//   overflow       sticky: write or pktend attempted while full

module fx2_in_ep_fifo #(
    parameter logic [1:0] FIFOADR   = 2'd0,
    parameter int         WIDTH     = 8,
    parameter int         PKT_WORDS = 256,
    parameter int         NUM_PKTS  = 4
) (
    input  logic                             ifclk,
    input  logic                             reset_n,
    input  logic [1:0]                       fifoadr,
    input  logic [WIDTH-1:0]                 data,
    input  logic                             slwr,
    input  logic                             pktend,
    output logic                             full,
    input  logic                             host_rd,
    output logic [WIDTH-1:0]                 host_data,
    output logic                             host_pkt_avail,
    output logic [$clog2(PKT_WORDS+1)-1:0]   host_pkt_len,
    output logic                             host_eop,
    output logic                             overflow
);

    localparam int LW    = $clog2(PKT_WORDS + 1);
    localparam int SW    = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
    localparam int CW    = $clog2(NUM_PKTS + 1);
    localparam int DEPTH = NUM_PKTS * PKT_WORDS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [SW-1:0] wr_slot_q, wr_slot_d;
    logic [SW-1:0] rd_slot_q, rd_slot_d;
    logic [LW-1:0] cur_len_q, cur_len_d;
    logic [LW-1:0] rd_idx_q,  rd_idx_d;
    logic [CW-1:0] pkt_count_q, pkt_count_d;
    logic [LW-1:0] len_q [NUM_PKTS];
    logic          overflow_q, overflow_d;

    logic          sel;
    logic          wr_acc;
    logic          commit;
    logic          pop;
    logic          advance;
    logic          ovf_evt;
    logic [LW-1:0] len_next;
    logic [LW-1:0] head_len;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    assign sel      = (fifoadr == FIFOADR);
    assign full     = (pkt_count_q == CW'(NUM_PKTS));
    assign wr_acc   = sel && slwr && !full;
    assign ovf_evt  = sel && (slwr || pktend) && full;
    assign len_next = wr_acc ? (cur_len_q + LW'(1)) : cur_len_q;
    // A write that fills the packet and a coincident pktend both land here,
    // so only one commit is ever produced per cycle.
    assign commit   = (wr_acc && (cur_len_q == LW'(PKT_WORDS - 1))) ||
                      (sel && pktend && !full);

    assign head_len       = len_q[rd_slot_q];
    assign host_pkt_avail = (pkt_count_q != '0);
    assign host_pkt_len   = head_len;
    assign host_eop       = host_pkt_avail &&
                            ((head_len == '0) || ((rd_idx_q + LW'(1)) == head_len));
    assign pop            = host_rd && host_eop;
    assign advance        = host_rd && host_pkt_avail && !host_eop;

    assign wr_addr   = AW'(wr_slot_q) * AW'(PKT_WORDS) + AW'(cur_len_q);
    assign rd_addr   = AW'(rd_slot_q) * AW'(PKT_WORDS) + AW'(rd_idx_q);
    assign host_data = mem[rd_addr];
    assign overflow  = overflow_q;

    always_comb begin
        wr_slot_d   = wr_slot_q;
        cur_len_d   = cur_len_q;
        rd_slot_d   = rd_slot_q;
        rd_idx_d    = rd_idx_q;
        pkt_count_d = pkt_count_q;
        overflow_d  = overflow_q || ovf_evt;

        if (commit) begin
            wr_slot_d = (wr_slot_q == SW'(NUM_PKTS - 1)) ? '0 : wr_slot_q + SW'(1);
            cur_len_d = '0;
        end else if (wr_acc) begin
            cur_len_d = cur_len_q + LW'(1);
        end

        if (pop) begin
            rd_slot_d = (rd_slot_q == SW'(NUM_PKTS - 1)) ? '0 : rd_slot_q + SW'(1);
            rd_idx_d  = '0;
        end else if (advance) begin
            rd_idx_d  = rd_idx_q + LW'(1);
        end

        // Commit and pop in the same cycle cancel out.
        case ({commit, pop})
            2'b10:   pkt_count_d = pkt_count_q + CW'(1);
            2'b01:   pkt_count_d = pkt_count_q - CW'(1);
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_slot_q   <= '0;
            cur_len_q   <= '0;
            rd_slot_q   <= '0;
            rd_idx_q    <= '0;
            pkt_count_q <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < NUM_PKTS; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            wr_slot_q   <= wr_slot_d;
            cur_len_q   <= cur_len_d;
            rd_slot_q   <= rd_slot_d;
            rd_idx_q    <= rd_idx_d;
            pkt_count_q <= pkt_count_d;
            overflow_q  <= overflow_d;
            if (commit) begin
                len_q[wr_slot_q] <= len_next;
            end
        end
    end

    // Packet storage has no reset; stale contents are never exposed as valid
    // because the host side only reads committed lengths.
    always_ff @(posedge ifclk) begin
        if (wr_acc) begin
            mem[wr_addr] <= data;
        end
    end

`ifdef FX2_MODEL_TRACE_EN
    always_ff @(posedge ifclk) begin
        if (reset_n) begin
            if (wr_acc) begin
                $display("%2b IN %x", FIFOADR, data);
            end
            if (commit) begin
                $display("%2b: PKTEND len=%0d", FIFOADR, len_next);
            end
            if (ovf_evt) begin
                $display("%2b: OVERFLOW", FIFOADR);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_fx2_in_ep_fifo.sv
// tb/tb_fx2_in_ep_fifo.sv - directed self-checking bench for fx2_in_ep_fifo

module tb_fx2_in_ep_fifo;

    logic       ifclk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] fifoadr = 2'd1;
    logic [7:0] data = 8'h00;
    logic       slwr = 1'b0;
    logic       pktend = 1'b0;
    logic       full;
    logic       host_rd = 1'b0;
    logic [7:0] host_data;
    logic       host_pkt_avail;
    logic [2:0] host_pkt_len;
    logic       host_eop;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    fx2_in_ep_fifo #(
        .FIFOADR  (2'd1),
        .WIDTH    (8),
        .PKT_WORDS(4),
        .NUM_PKTS (4)
    ) dut (
        .ifclk         (ifclk),
        .reset_n       (reset_n),
        .fifoadr       (fifoadr),
        .data          (data),
        .slwr          (slwr),
        .pktend        (pktend),
        .full          (full),
        .host_rd       (host_rd),
        .host_data     (host_data),
        .host_pkt_avail(host_pkt_avail),
        .host_pkt_len  (host_pkt_len),
        .host_eop      (host_eop),
        .overflow      (overflow)
    );

    always #5 ifclk = ~ifclk;

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge ifclk); #1;
        reset_n = 1'b1;
    endtask

    task automatic wr(input logic w, input logic [7:0] d, input logic pe);
        slwr = w; data = d; pktend = pe;
        @(posedge ifclk); #1;
        slwr = 1'b0; pktend = 1'b0;
    endtask

    task automatic rd();
        host_rd = 1'b1;
        @(posedge ifclk); #1;
        host_rd = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", full); end
        n_cmp++; if (host_pkt_avail !== 1'b0) begin n_err++; $display("FAIL reset_avail got %b exp 0", host_pkt_avail); end
        n_cmp++; if (host_eop !== 1'b0) begin n_err++; $display("FAIL reset_eop got %b exp 0", host_eop); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        n_cmp++; if (host_pkt_len !== 3'd0) begin n_err++; $display("FAIL reset_len got %0d exp 0", host_pkt_len); end
        @(posedge ifclk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        for (int i = 0; i < 3; i++) wr(1'b1, exp_d[i], 1'b0);
        n_cmp++; if (host_pkt_avail !== 1'b0) begin n_err++; $display("FAIL basic_avail_pre got %b exp 0", host_pkt_avail); end
        wr(1'b0, 8'h00, 1'b1);
        n_cmp++; if (host_pkt_avail !== 1'b1) begin n_err++; $display("FAIL basic_avail got %b exp 1", host_pkt_avail); end
        n_cmp++; if (host_pkt_len !== 3'd3) begin n_err++; $display("FAIL basic_len got %0d exp 3", host_pkt_len); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (host_data !== exp_d[i]) begin n_err++; $display("FAIL basic_data%0d got %h exp %h", i, host_data, exp_d[i]); end
            n_cmp++; if (host_eop !== (i == 2)) begin n_err++; $display("FAIL basic_eop%0d got %b exp %b", i, host_eop, (i == 2)); end
            rd();
        end
        n_cmp++; if (host_pkt_avail !== 1'b0) begin n_err++; $display("FAIL basic_avail_post got %b exp 0", host_pkt_avail); end
    endtask

    task automatic drain_seq(input string tag, input int npk, input int lens [4], input logic [7:0] base);
        logic [7:0] k;
        k = base;
        for (int p = 0; p < npk; p++) begin
            n_cmp++; if (host_pkt_len !== 3'(lens[p])) begin n_err++; $display("FAIL %s_len%0d got %0d exp %0d", tag, p, host_pkt_len, lens[p]); end
            for (int w = 0; w < lens[p]; w++) begin
                n_cmp++; if (host_data !== k) begin n_err++; $display("FAIL %s_data got %h exp %h", tag, host_data, k); end
                n_cmp++; if (host_eop !== (w == lens[p] - 1)) begin n_err++; $display("FAIL %s_eop got %b exp %b", tag, host_eop, (w == lens[p] - 1)); end
                rd();
                k = k + 8'd1;
            end
        end
        n_cmp++; if (host_pkt_avail !== 1'b0) begin n_err++; $display("FAIL %s_empty got %b exp 0", tag, host_pkt_avail); end
    endtask

    task automatic test_autocommit();
        int lens [4];
        for (int i = 0; i < 10; i++) wr(1'b1, 8'(i), 1'b0);
        n_cmp++; if (host_pkt_avail !== 1'b1) begin n_err++; $display("FAIL auto_avail got %b exp 1", host_pkt_avail); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL auto_full got %b exp 0", full); end
        wr(1'b0, 8'h00, 1'b1);
        lens[0] = 4; lens[1] = 4; lens[2] = 2; lens[3] = 0;
        drain_seq("auto", 3, lens, 8'h00);
    endtask

    task automatic test_coincide();
        int lens [4];
        for (int i = 0; i < 3; i++) wr(1'b1, 8'hC0 + 8'(i), 1'b0);
        wr(1'b1, 8'hC3, 1'b1);
        wr(1'b1, 8'hC4, 1'b1);
        lens[0] = 4; lens[1] = 1; lens[2] = 0; lens[3] = 0;
        drain_seq("coin", 2, lens, 8'hC0);
    endtask

    task automatic test_zlp();
        wr(1'b0, 8'h00, 1'b1);
        n_cmp++; if (host_pkt_avail !== 1'b1) begin n_err++; $display("FAIL zlp_avail got %b exp 1", host_pkt_avail); end
        n_cmp++; if (host_pkt_len !== 3'd0) begin n_err++; $display("FAIL zlp_len got %0d exp 0", host_pkt_len); end
        n_cmp++; if (host_eop !== 1'b1) begin n_err++; $display("FAIL zlp_eop got %b exp 1", host_eop); end
        rd();
        n_cmp++; if (host_pkt_avail !== 1'b0) begin n_err++; $display("FAIL zlp_popped got %b exp 0", host_pkt_avail); end
    endtask

    task automatic test_unselected();
        fifoadr = 2'd2;
        for (int i = 0; i < 3; i++) wr(1'b1, 8'h99, 1'b1);
        fifoadr = 2'd1;
        n_cmp++; if (host_pkt_avail !== 1'b0) begin n_err++; $display("FAIL unsel_avail got %b exp 0", host_pkt_avail); end
        rd();
        wr(1'b1, 8'h5A, 1'b1);
        n_cmp++; if (host_pkt_len !== 3'd1) begin n_err++; $display("FAIL unsel_len got %0d exp 1", host_pkt_len); end
        n_cmp++; if (host_data !== 8'h5A) begin n_err++; $display("FAIL unsel_data got %h exp 5a", host_data); end
        n_cmp++; if (host_eop !== 1'b1) begin n_err++; $display("FAIL unsel_eop got %b exp 1", host_eop); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL unsel_ovf got %b exp 0", overflow); end
        rd();
        n_cmp++; if (host_pkt_avail !== 1'b0) begin n_err++; $display("FAIL unsel_empty got %b exp 0", host_pkt_avail); end
    endtask

    task automatic test_full_wrap();
        logic [7:0] exp_d [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr(1'b1, 8'hA0 + 8'(i), 1'b1);
            n_cmp++; if (full !== (i == 3)) begin n_err++; $display("FAIL full_after%0d got %b exp %b", i, full, (i == 3)); end
        end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_ovf_pre got %b exp 0", overflow); end
        wr(1'b1, 8'hEE, 1'b0);
        wr(1'b0, 8'h00, 1'b1);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL full_ovf got %b exp 1", overflow); end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL full_still got %b exp 1", full); end
        n_cmp++; if (host_data !== 8'hA0) begin n_err++; $display("FAIL full_head got %h exp a0", host_data); end
        // pop and a write in the same cycle: the write must still be refused
        host_rd = 1'b1; slwr = 1'b1; data = 8'hEF;
        @(posedge ifclk); #1;
        host_rd = 1'b0; slwr = 1'b0;
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL full_freed got %b exp 0", full); end
        wr(1'b1, 8'h55, 1'b1);
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL full_wrap got %b exp 1", full); end
        exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3; exp_d[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (host_pkt_len !== 3'd1) begin n_err++; $display("FAIL wrap_len%0d got %0d exp 1", i, host_pkt_len); end
            n_cmp++; if (host_data !== exp_d[i]) begin n_err++; $display("FAIL wrap_data%0d got %h exp %h", i, host_data, exp_d[i]); end
            rd();
        end
        n_cmp++; if (host_pkt_avail !== 1'b0) begin n_err++; $display("FAIL wrap_empty got %b exp 0", host_pkt_avail); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_reset_mid();
        wr(1'b1, 8'h31, 1'b1);
        wr(1'b1, 8'h41, 1'b0);
        wr(1'b1, 8'h42, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL rmid_full got %b exp 0", full); end
        n_cmp++; if (host_pkt_avail !== 1'b0) begin n_err++; $display("FAIL rmid_avail got %b exp 0", host_pkt_avail); end
        n_cmp++; if (host_eop !== 1'b0) begin n_err++; $display("FAIL rmid_eop got %b exp 0", host_eop); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rmid_ovf got %b exp 0", overflow); end
        n_cmp++; if (host_pkt_len !== 3'd0) begin n_err++; $display("FAIL rmid_len got %0d exp 0", host_pkt_len); end
        @(posedge ifclk); #1;
        reset_n = 1'b1;
        wr(1'b1, 8'h77, 1'b0);
        wr(1'b1, 8'h88, 1'b1);
        n_cmp++; if (host_pkt_len !== 3'd2) begin n_err++; $display("FAIL rmid_newlen got %0d exp 2", host_pkt_len); end
        n_cmp++; if (host_data !== 8'h77) begin n_err++; $display("FAIL rmid_d0 got %h exp 77", host_data); end
        rd();
        n_cmp++; if (host_data !== 8'h88) begin n_err++; $display("FAIL rmid_d1 got %h exp 88", host_data); end
        n_cmp++; if (host_eop !== 1'b1) begin n_err++; $display("FAIL rmid_eop1 got %b exp 1", host_eop); end
        rd();
        n_cmp++; if (host_pkt_avail !== 1'b0) begin n_err++; $display("FAIL rmid_empty got %b exp 0", host_pkt_avail); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_autocommit();
        test_coincide();
        test_zlp();
        test_unselected();
        test_full_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
